// File: rtl/joy_dir_filter_if.sv
// Joystick filter bus: raw joystick words in, conditioned words out.
//   master : host side (drives raw in_dir/in_fire, observes filtered outputs)
//   slave  : joy_dir_filter side
// Signals (per channel c):
//   in_dir[4c+3:4c]  raw {up,down,left,right}
//   in_fire[c]       raw fire
//   turbo_en[c]      turbo enable (only when JOYDIR_TURBO_EN is defined)
//   out_dir          filtered directions, same packing as in_dir
//   out_fire         debounced (optionally turbo-modulated) fire
//   changed          one-cycle pulse when out_dir for that channel changes
interface joy_dir_filter_if #(parameter int CHANNELS = 2);
  logic [4*CHANNELS-1:0] in_dir;
  logic [CHANNELS-1:0]   in_fire;
`ifdef JOYDIR_TURBO_EN
  logic [CHANNELS-1:0]   turbo_en;
`endif
  logic [4*CHANNELS-1:0] out_dir;
  logic [CHANNELS-1:0]   out_fire;
  logic [CHANNELS-1:0]   changed;

`ifdef JOYDIR_TURBO_EN
  modport master (output in_dir, in_fire, turbo_en, input out_dir, out_fire, changed);
  modport slave  (input in_dir, in_fire, turbo_en, output out_dir, out_fire, changed);
`else
  modport master (output in_dir, in_fire, input out_dir, out_fire, changed);
  modport slave  (input in_dir, in_fire, output out_dir, out_fire, changed);
`endif
endinterface

// File: rtl/joy_dir_filter.sv
// Multi-channel joystick conditioner: per-bit synchroniser + debounce, then a
// runtime-selectable direction filter per channel:
//   mode 0 passthrough, 1 4-way last-pressed, 2 4-way first-held,
//   3 8-way with opposite-direction cancel.
// Optional macro JOYDIR_TURBO_EN adds per-channel turbo fire (jif.turbo_en).
// Ports:
//   clk_sys  system clock
//   reset_n  asynchronous active-low reset
//   ce       sample enable; debounce and mode logic advance only when high
//   mode     direction mode select
//   deb_len  extra ce ticks a changed bit must persist before acceptance
//   jif      joy_dir_filter_if.slave (raw in, filtered out, changed pulses)

// One player channel: 4 direction bits + fire share the same debounce logic
// (bit 4 is fire).
module joy_dir_chan #(
  parameter int DEB_BITS  = 4,
  parameter int TURBO_DIV = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                ce_d,
  input  logic [1:0]          mode,
  input  logic                mode_chg,
  input  logic [DEB_BITS-1:0] deb_len,
  input  logic [3:0]          raw_dir,
  input  logic                raw_fire,
`ifdef JOYDIR_TURBO_EN
  input  logic                turbo_en,
`endif
  output logic [3:0]          out_dir,
  output logic                out_fire,
  output logic                changed
);
  logic [4:0]                sync1, sync2, stable, stable_nxt;
  logic [4:0][DEB_BITS-1:0]  cnt, cnt_nxt;
  logic [3:0]                mask, mask_nxt, s, np, dir_f;
  logic                      fire_f;

  // up > down > left > right
  function automatic logic [3:0] top_bit(input logic [3:0] x);
    if (x[3])      return 4'b1000;
    else if (x[2]) return 4'b0100;
    else if (x[1]) return 4'b0010;
    else if (x[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {raw_fire, raw_dir};
      sync2 <= sync1;
    end

  // Counter only runs while sync disagrees with stable and is cleared on
  // acceptance, so it never passes deb_len (>= also covers deb_len shrinking).
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int b = 0; b < 5; b++) begin
      if (sync2[b] == stable[b]) begin
        cnt_nxt[b] = '0;
      end else if (cnt[b] >= deb_len) begin
        stable_nxt[b] = sync2[b];
        cnt_nxt[b]    = '0;
      end else begin
        cnt_nxt[b] = cnt[b] + 1'b1;
      end
    end
  end

  // Mask is resolved against the stable value being accepted this tick, with
  // the current stable register serving as the previous tick's value. This
  // lets stable and mask land on the same ce edge.
  assign s  = stable_nxt[3:0];
  assign np = s & ~stable[3:0];

  always_comb begin
    mask_nxt = mask;
    case (mode)
      2'd1: begin
        if (np != 4'b0)             mask_nxt = top_bit(np);
        else if ((s & mask) == 4'b0) mask_nxt = top_bit(s);
      end
      2'd2: if ((s & mask) == 4'b0) mask_nxt = top_bit(s);
      default: mask_nxt = 4'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      stable <= '0;
      cnt    <= '0;
      mask   <= '0;
    end else begin
      if (ce) begin
        stable <= stable_nxt;
        cnt    <= cnt_nxt;
      end
      if (mode_chg) mask <= '0;
      else if (ce)  mask <= mask_nxt;
    end

  always_comb begin
    dir_f = stable[3:0];
    case (mode)
      2'd1, 2'd2: dir_f = stable[3:0] & mask;
      2'd3: begin
        if (stable[3] && stable[2]) dir_f[3:2] = 2'b00;
        if (stable[1] && stable[0]) dir_f[1:0] = 2'b00;
      end
      default: ;
    endcase
  end

`ifdef JOYDIR_TURBO_EN
  localparam int TW = (TURBO_DIV < 2) ? 1 : $clog2(TURBO_DIV);
  logic          ph;
  logic [TW-1:0] tcnt;

  // Phase starts high on the press tick and flips every TURBO_DIV ce ticks.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      ph   <= 1'b0;
      tcnt <= '0;
    end else if (ce) begin
      if (!stable_nxt[4]) begin
        ph   <= 1'b0;
        tcnt <= '0;
      end else if (!stable[4]) begin
        ph   <= 1'b1;
        tcnt <= '0;
      end else if (tcnt == TW'(TURBO_DIV - 1)) begin
        ph   <= ~ph;
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end

  assign fire_f = turbo_en ? ph : stable[4];
`else
  assign fire_f = stable[4];
`endif

  // Outputs are sampled the cycle after a ce tick, so a mode change alone
  // does not move them until the next tick.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      out_dir  <= '0;
      out_fire <= 1'b0;
      changed  <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (ce_d) begin
        out_dir  <= dir_f;
        out_fire <= fire_f;
        changed  <= (dir_f != out_dir);
      end
    end
endmodule

module joy_dir_filter #(
  parameter int CHANNELS  = 2,
  parameter int DEB_BITS  = 4,
  parameter int TURBO_DIV = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ce,
  input  logic [1:0]          mode,
  input  logic [DEB_BITS-1:0] deb_len,
  joy_dir_filter_if.slave     jif
);
  logic       ce_d, mode_chg;
  logic [1:0] mode_q;
  logic [CHANNELS-1:0][3:0] dir_o;
  logic [CHANNELS-1:0]      fire_o, chg_o;

  assign mode_chg = (mode != mode_q);

  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      ce_d   <= 1'b0;
      mode_q <= 2'd0;
    end else begin
      ce_d   <= ce;
      mode_q <= mode;
    end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    joy_dir_chan #(.DEB_BITS(DEB_BITS), .TURBO_DIV(TURBO_DIV)) u_ch (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .ce       (ce),
      .ce_d     (ce_d),
      .mode     (mode),
      .mode_chg (mode_chg),
      .deb_len  (deb_len),
      .raw_dir  (jif.in_dir[4*c +: 4]),
      .raw_fire (jif.in_fire[c]),
`ifdef JOYDIR_TURBO_EN
      .turbo_en (jif.turbo_en[c]),
`endif
      .out_dir  (dir_o[c]),
      .out_fire (fire_o[c]),
      .changed  (chg_o[c])
    );
  end

  assign jif.out_dir  = dir_o;
  assign jif.out_fire = fire_o;
  assign jif.changed  = chg_o;
endmodule

// File: tb/tb_joy_dir_filter.sv
// Self-checking bench for joy_dir_filter (default build). Every ce tick spans
// five clk_sys cycles: inputs change at the tick start, ce is high for the
// fourth edge, and outputs are sampled after the fifth. A tick-level
// reference model tracks debounce, masks and expected outputs.
module tb_joy_dir_filter;
  localparam int CH = 2;
  localparam int DB = 4;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce      = 1'b0;
  logic [1:0]    mode    = 2'd0;
  logic [DB-1:0] deb_len = '0;
  int            n_chk   = 0;
  int            n_fail  = 0;

  joy_dir_filter_if #(.CHANNELS(CH)) jif ();

  joy_dir_filter #(.CHANNELS(CH), .DEB_BITS(DB), .TURBO_DIV(4)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .mode    (mode),
    .deb_len (deb_len),
    .jif     (jif.slave)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- reference model (one call per ce tick) ----------------
  logic [5*CH-1:0] m_st;
  int              m_cnt [5*CH];
  logic [3:0]      m_mask [CH];
  logic [1:0]      m_mode;
  logic [4*CH-1:0] exp_dir;
  logic [CH-1:0]   exp_fire;

  function automatic logic [3:0] first_of(input logic [3:0] x);
    for (int i = 3; i >= 0; i--)
      if (x[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_st = '0;
    for (int b = 0; b < 5*CH; b++) m_cnt[b] = 0;
    for (int c = 0; c < CH; c++) m_mask[c] = 4'b0;
    m_mode   = mode;
    exp_dir  = '0;
    exp_fire = '0;
  endtask

  task automatic model_tick();
    logic [5*CH-1:0] raw, nst;
    logic [3:0] s, p, np, o;
    raw = {jif.in_fire, jif.in_dir};
    nst = m_st;
    if (mode != m_mode) begin
      for (int c = 0; c < CH; c++) m_mask[c] = 4'b0;
      m_mode = mode;
    end
    for (int b = 0; b < 5*CH; b++) begin
      if (raw[b] == m_st[b]) m_cnt[b] = 0;
      else if (m_cnt[b] >= int'(deb_len)) begin nst[b] = raw[b]; m_cnt[b] = 0; end
      else m_cnt[b]++;
    end
    for (int c = 0; c < CH; c++) begin
      s  = nst[4*c +: 4];
      p  = m_st[4*c +: 4];
      np = s & ~p;
      if (mode == 2'd1) begin
        if (np != 0) m_mask[c] = first_of(np);
        else if ((s & m_mask[c]) == 0) m_mask[c] = first_of(s);
      end else if (mode == 2'd2) begin
        if ((s & m_mask[c]) == 0) m_mask[c] = first_of(s);
      end else begin
        m_mask[c] = 4'b0;
      end
      if (mode == 2'd0)      o = s;
      else if (mode == 2'd3) o = {(s[3] && s[2]) ? 2'b00 : s[3:2], (s[1] && s[0]) ? 2'b00 : s[1:0]};
      else                   o = s & m_mask[c];
      exp_dir[4*c +: 4] = o;
    end
    m_st     = nst;
    exp_fire = nst[4*CH +: CH];
  endtask

  // One ce tick: run the clocks, advance the model, check outputs and the
  // number of changed pulses seen per channel during the tick.
  task automatic do_tick(input string tag, output int chg0);
    logic [4*CH-1:0] prev;
    int chg [CH];
    int want;
    for (int c = 0; c < CH; c++) chg[c] = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      for (int c = 0; c < CH; c++) chg[c] += int'(jif.changed[c]);
      if (k == 3) ce = 1'b1;
      if (k == 4) ce = 1'b0;
    end
    prev = exp_dir;
    model_tick();
    n_chk++;
    if (jif.out_dir !== exp_dir) begin
      n_fail++;
      $display("FAIL %s out_dir got=%b want=%b", tag, jif.out_dir, exp_dir);
    end
    n_chk++;
    if (jif.out_fire !== exp_fire) begin
      n_fail++;
      $display("FAIL %s out_fire got=%b want=%b", tag, jif.out_fire, exp_fire);
    end
    for (int c = 0; c < CH; c++) begin
      want = (exp_dir[4*c +: 4] != prev[4*c +: 4]) ? 1 : 0;
      n_chk++;
      if (chg[c] != want) begin
        n_fail++;
        $display("FAIL %s changed[%0d] pulses got=%0d want=%0d", tag, c, chg[c], want);
      end
    end
    chg0 = chg[0];
  endtask

  task automatic apply_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    ce      = 1'b0;
    repeat (2) @(negedge clk_sys);
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic check_dir0(input string tag, input logic [3:0] want);
    n_chk++;
    if (jif.out_dir[3:0] !== want) begin
      n_fail++;
      $display("FAIL %s ch0 dir got=%b want=%b", tag, jif.out_dir[3:0], want);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int d;
    jif.in_dir  = '1;
    jif.in_fire = '1;
    reset_n     = 1'b0;
    repeat (4) @(negedge clk_sys);
    n_chk++;
    if (jif.out_dir !== '0) begin n_fail++; $display("FAIL reset out_dir got=%b want=0", jif.out_dir); end
    n_chk++;
    if (jif.out_fire !== '0) begin n_fail++; $display("FAIL reset out_fire got=%b want=0", jif.out_fire); end
    n_chk++;
    if (jif.changed !== '0) begin n_fail++; $display("FAIL reset changed got=%b want=0", jif.changed); end
    jif.in_dir  = '0;
    jif.in_fire = '0;
    model_reset();
    reset_n = 1'b1;
    do_tick("reset_idle", d);
    check_dir0("reset_idle", 4'b0000);
  endtask

  task automatic test_debounce();
    int d, tot;
    apply_reset();
    mode = 2'd0; deb_len = 4'd3;
    jif.in_dir = 8'h01;
    do_tick("glitch1", d); check_dir0("glitch1", 4'b0000);
    do_tick("glitch2", d); check_dir0("glitch2", 4'b0000);
    jif.in_dir = 8'h00;
    do_tick("glitch_off", d); check_dir0("glitch_off", 4'b0000);
    jif.in_dir = 8'h01;
    tot = 0;
    for (int i = 1; i <= 4; i++) begin
      do_tick("hold", d);
      tot += d;
      check_dir0("hold", (i == 4) ? 4'b0001 : 4'b0000);
    end
    n_chk++;
    if (tot != 1) begin n_fail++; $display("FAIL deb_changed_total got=%0d want=1", tot); end
  endtask

  task automatic test_mode1();
    int d;
    apply_reset();
    mode = 2'd1; deb_len = 4'd0;
    jif.in_dir = 8'h02; do_tick("m1_left", d);    check_dir0("m1_left", 4'b0010);
    jif.in_dir = 8'h0A; do_tick("m1_add_up", d);  check_dir0("m1_add_up", 4'b1000);
    jif.in_dir = 8'h02; do_tick("m1_rel_up", d);  check_dir0("m1_rel_up", 4'b0010);
    jif.in_dir = 8'h00; do_tick("m1_rel_all", d); check_dir0("m1_rel_all", 4'b0000);
    // simultaneous newpresses on both channels
    jif.in_dir = {4'b0110, 4'b1001};
    do_tick("m1_simul", d);
    check_dir0("m1_simul", 4'b1000);
    n_chk++;
    if (jif.out_dir[7:4] !== 4'b0100) begin
      n_fail++;
      $display("FAIL m1_simul ch1 dir got=%b want=0100", jif.out_dir[7:4]);
    end
  endtask

  task automatic test_mode2();
    int d;
    mode = 2'd2; jif.in_dir = 8'h00;
    do_tick("m2_idle", d);
    jif.in_dir = 8'h04; do_tick("m2_down", d);     check_dir0("m2_down", 4'b0100);
    jif.in_dir = 8'h06; do_tick("m2_add_left", d); check_dir0("m2_add_left", 4'b0100);
    jif.in_dir = 8'h02; do_tick("m2_rel_down", d); check_dir0("m2_rel_down", 4'b0010);
  endtask

  task automatic test_mode3();
    int d;
    mode = 2'd3;
    jif.in_dir = 8'h0D; do_tick("m3_udr", d); check_dir0("m3_udr", 4'b0001);
    jif.in_dir = 8'h03; do_tick("m3_lr", d);  check_dir0("m3_lr", 4'b0000);
    jif.in_dir = 8'h0D; do_tick("m3_udr2", d); check_dir0("m3_udr2", 4'b0001);
    mode = 2'd0;        do_tick("m3_to_m0", d); check_dir0("m3_to_m0", 4'b1101);
  endtask

  task automatic test_reset_mid();
    int d;
    mode = 2'd1; deb_len = 4'd3; jif.in_dir = 8'h08;
    do_tick("mid_pre1", d);
    do_tick("mid_pre2", d);
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      do_tick("mid_post", d);
      check_dir0("mid_post", (i == 4) ? 4'b1000 : 4'b0000);
    end
  endtask

  task automatic test_ce_gate();
    int d;
    mode = 2'd0; deb_len = 4'd0; jif.in_dir = 8'h44; jif.in_fire = 2'b11;
    repeat (12) begin
      @(negedge clk_sys);
      n_chk++;
      if (jif.out_dir !== exp_dir || jif.changed !== '0) begin
        n_fail++;
        $display("FAIL ce_gate got dir=%b chg=%b want dir=%b chg=00", jif.out_dir, jif.changed, exp_dir);
      end
    end
    do_tick("ce_gate_tick", d);
    check_dir0("ce_gate_tick", 4'b0100);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) jif.in_dir  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) jif.in_fire = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) deb_len = 4'($urandom_range(0, 3));
      do_tick("random", d);
    end
  endtask

  initial begin
    jif.in_dir  = '0;
    jif.in_fire = '0;
`ifdef JOYDIR_TURBO_EN
    jif.turbo_en = '0;
`endif
    model_reset();
    test_reset();
    test_debounce();
    test_mode1();
    test_mode2();
    test_mode3();
    test_reset_mid();
    test_ce_gate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/joy_dir_filter.md
Name: joy_dir_filter

Overview:
- Multi-channel joystick conditioner between hps_io joystick words and the game core's in0/in1 assembly.
- Generalises the single-player one-direction filter to CHANNELS players with per-bit debounce and four runtime-selectable direction modes: passthrough, 4-way last-pressed, 4-way first-held, 8-way with opposite-direction cancel.
- Fire buttons are debounced and passed alongside the directions.

Parameters:
CHANNELS, 2, number of player channels
DEB_BITS, 4, width of the per-bit debounce counter and of deb_len
TURBO_DIV, 4, ce ticks per turbo half-period (used only with JOYDIR_TURBO_EN)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  sample enable; debounce and mode logic advance only on ce=1
mode  in  2  0=passthrough, 1=4-way last-pressed, 2=4-way first-held, 3=8-way opposite-cancel
deb_len  in  DEB_BITS  stable ce ticks required before a bit change is accepted
in_dir  in  4*CHANNELS  raw directions; per channel {up,down,left,right} at [4c+3:4c]
in_fire  in  CHANNELS  raw fire, one bit per channel
out_dir  out  4*CHANNELS  filtered directions, same packing as in_dir
out_fire  out  CHANNELS  debounced fire
changed  out  CHANNELS  one-cycle pulse when that channel's out_dir changes

Behaviour:
- Reset: all synchronisers, stable bits, counters, masks, out_dir, out_fire and changed clear to 0.
  - Asserting reset mid-debounce or mid-hold discards all state.
- Input path: two-flop synchroniser on every in_dir and in_fire bit, clocked every clk_sys cycle.
- Debounce, per bit, on ce:
  - sync==stable: counter <= 0.
  - Otherwise: counter increments; when counter==deb_len, stable <= sync and counter <= 0.
  - deb_len=0: stable follows sync on every ce tick.
- Per channel, s = stable dirs and p = s from the previous ce tick; newpress = s & ~p.
- Modes:
  - Mode 0: out = s.
  - Mode 1, one-hot mask:
    - Any newpress: mask <= highest-index newpress bit (up>down>left>right).
    - Else if (s & mask)==0: mask <= highest-index bit of s, or 0 if none.
    - out = s & mask.
  - Mode 2, one-hot mask:
    - newpress is ignored while (s & mask)!=0.
    - When the held bit releases: mask <= highest-index bit of s, or 0.
    - out = s & mask.
  - Mode 3: out = s with up&down both cleared when both set, and left&right both cleared when both set.
- Mode change: detected on any clk_sys edge. All masks clear the next cycle; outputs are then recomputed on the next ce tick under the new mode.
- Timing:
  - out_dir and out_fire are registered and update on the clk_sys edge following the ce tick in which stable/mask change. Minimum latency from pin to output is synchroniser (2) + 1 ce tick + 1 clk_sys.
  - changed[c] is high for exactly one clk_sys cycle, the cycle after out_dir[c] takes a new value.
- Channels are fully independent. Simultaneous newpresses on different channels are each resolved per the mode.
- Counter saturation: counters never exceed deb_len, so there is no wrap.

Optional Feature:
JOYDIR_TURBO_EN:
- Defined:
  - Adds input turbo_en[CHANNELS].
  - When turbo_en[c]=1 and debounced fire[c] is held, out_fire[c] goes 1 on the press tick, then toggles every TURBO_DIV ce ticks.
  - Release forces out_fire[c]=0 and resets the turbo counter.
  - turbo_en[c]=0 behaves exactly as without the macro.
- Undefined: turbo_en is absent; out_fire = debounced fire.

Test Plan:
1. Reset and deb_len=3, ce every 4 clocks: right pulses for 2 ce ticks (glitch) -> out_dir stays 0. Held 4 ce ticks -> out_dir[0]=1; changed pulses once.
2. Mode 1, channel 0: hold left, then add up -> out 4'b1000. Release up while left held -> out 4'b0010. Release left -> 0.
3. Mode 1, up and right pressed on the same ce tick -> out 4'b1000.
4. Mode 2: hold down, add left -> out 4'b0100. Release down -> 4'b0010.
5. Mode 3: up+down+right held -> out 4'b0001. left+right -> 0. Switch to mode 0 mid-hold -> 4'b1101 after next ce tick.
6. JOYDIR_TURBO_EN, TURBO_DIV=4, fire held 16 ce ticks with turbo_en=1 -> out_fire 1,0,1,0 in 4-tick phases. Release -> 0 next ce.
